// File: rtl/clk_div_gen_if.sv
// ---------------------------------------------------------------------------
// clk_div_gen_if
// Control/status bundle between a clock-divider user and clk_div_gen.
// EDGE_CNT is present only when CLK_DIV_GEN_EDGE_COUNT_EN is defined.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface clk_div_gen_if #(
  parameter int DIV_W = 8
);
  logic             EN;
  logic [DIV_W-1:0] DIV;
  logic             LOAD;
  logic             LOAD_ACK;
  logic             PEND;
  logic             ACTIVE;
  logic             RISE;
  logic             O;
`ifdef CLK_DIV_GEN_EDGE_COUNT_EN
  logic [31:0]      EDGE_CNT;

  modport master (output EN, DIV, LOAD,
                  input  LOAD_ACK, PEND, ACTIVE, RISE, O, EDGE_CNT);
  modport slave  (input  EN, DIV, LOAD,
                  output LOAD_ACK, PEND, ACTIVE, RISE, O, EDGE_CNT);
`else
  modport master (output EN, DIV, LOAD,
                  input  LOAD_ACK, PEND, ACTIVE, RISE, O);
  modport slave  (input  EN, DIV, LOAD,
                  output LOAD_ACK, PEND, ACTIVE, RISE, O);
`endif
endinterface

`default_nettype wire

// File: rtl/clk_div_gen.sv
// ---------------------------------------------------------------------------
// clk_div_gen
// Programmable divider producing a registered clock O from fabric clock C,
// intended as the source feeding a clock buffer input. Run/stop and ratio
// changes take effect only on period boundaries, so O never glitches.
// Optional: define CLK_DIV_GEN_EDGE_COUNT_EN to add the 32-bit EDGE_CNT
// rising-edge counter.
// DEFAULT_DIV must be >= 2 and < 2**DIV_W.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module clk_div_gen #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  wire logic      C,
  input  wire logic      R,
  clk_div_gen_if.slave   bus
);

  localparam logic [0:0]       c_IDLE    = 1'b0;
  localparam logic [0:0]       c_RUN     = 1'b1;
  localparam logic [DIV_W-1:0] c_DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] c_MIN_DIV = DIV_W'(2);

  logic [0:0]       state_q,   state_d;
  logic [DIV_W-1:0] cnt_q,     cnt_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_q,    pend_d;
  logic             o_q,       o_d;
  logic             rise_q,    rise_d;
  logic             ack_q,     ack_d;
  logic             active_q;
`ifdef CLK_DIV_GEN_EDGE_COUNT_EN
  logic [31:0]      edge_cnt_q;
`endif

  logic [DIV_W-1:0] w_load_div;
  logic [DIV_W-1:0] w_high;
  logic [DIV_W-1:0] w_cnt_inc;
  logic             w_wrap;

  // Ratios below 2 cannot form a high and a low phase, so they become 2.
  assign w_load_div = (bus.DIV < c_MIN_DIV) ? c_MIN_DIV : bus.DIV;
  // High phase gets the extra cycle for odd ratios: H = N - floor(N/2).
  assign w_high     = cur_div_q - (cur_div_q >> 1);
  assign w_cnt_inc  = cnt_q + 1'b1;
  assign w_wrap     = (cnt_q == (cur_div_q - 1'b1));

  // State register: all divider state, with synchronous reset.
  always_ff @(posedge C) begin
    if (R) begin
      state_q    <= c_IDLE;
      cnt_q      <= '0;
      cur_div_q  <= c_DEF_DIV;
      pend_div_q <= c_DEF_DIV;
      pend_q     <= 1'b0;
      o_q        <= 1'b0;
      rise_q     <= 1'b0;
      ack_q      <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      pend_q     <= pend_d;
      o_q        <= o_d;
      rise_q     <= rise_d;
      ack_q      <= ack_d;
      active_q   <= (state_d == c_RUN);
    end
  end

`ifdef CLK_DIV_GEN_EDGE_COUNT_EN
  // Count every generated rising edge, in step with the RISE pulse.
  always_ff @(posedge C) begin
    if (R) begin
      edge_cnt_q <= '0;
    end else if (rise_d) begin
      edge_cnt_q <= edge_cnt_q + 32'd1;
    end
  end
`endif

  // Next-state logic: period counting, boundary-only ratio/run changes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    pend_d     = pend_q;
    o_d        = o_q;
    rise_d     = 1'b0;
    ack_d      = 1'b0;
    case (state_q)
      c_IDLE: begin
        cnt_d = '0;
        o_d   = 1'b0;
        // No period is running, so any waiting ratio applies right away.
        if (pend_q) begin
          cur_div_d = pend_div_q;
          pend_d    = 1'b0;
          ack_d     = 1'b1;
        end
        if (bus.LOAD) begin
          cur_div_d = w_load_div;
          pend_d    = 1'b0;
          ack_d     = 1'b1;
        end
        if (bus.EN) begin
          state_d = c_RUN;
          o_d     = 1'b1;
          rise_d  = 1'b1;
        end
      end
      default: begin
        if (!w_wrap) begin
          cnt_d = w_cnt_inc;
          o_d   = (w_cnt_inc < w_high);
        end else begin
          // Period boundary: swap in a waiting ratio, then stop or restart.
          if (pend_q) begin
            cur_div_d = pend_div_q;
            pend_d    = 1'b0;
            ack_d     = 1'b1;
          end
          cnt_d = '0;
          if (!bus.EN) begin
            state_d = c_IDLE;
            o_d     = 1'b0;
          end else begin
            o_d    = 1'b1;
            rise_d = 1'b1;
          end
        end
        // A capture on the wrap edge waits for the following boundary.
        if (bus.LOAD) begin
          pend_div_d = w_load_div;
          pend_d     = 1'b1;
        end
      end
    endcase
  end

  // Output drive: every output comes straight from a register.
  always_comb begin
    bus.O        = o_q;
    bus.RISE     = rise_q;
    bus.LOAD_ACK = ack_q;
    bus.PEND     = pend_q;
    bus.ACTIVE   = active_q;
`ifdef CLK_DIV_GEN_EDGE_COUNT_EN
    bus.EDGE_CNT = edge_cnt_q;
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_gen.sv
// ---------------------------------------------------------------------------
// tb_clk_div_gen
// Scoreboard bench for clk_div_gen: the stimulus side predicts each output
// period (high/low length, start-of-period LOAD_ACK) from the ratio rules;
// a negedge monitor measures the periods O actually produces and compares.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_clk_div_gen;

  localparam int DIV_W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  clk_div_gen_if #(.DIV_W(DIV_W)) bus ();

  clk_div_gen #(.DIV_W(DIV_W), .DEFAULT_DIV(2)) dut (
    .C   (clk),
    .R   (rst),
    .bus (bus)
  );

  typedef struct {
    int h;
    int l;
    bit ack;
  } per_t;

  per_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: measure each period between RISE pulses (or until ACTIVE drops).
  bit meas   = 1'b0;
  bit prev_o = 1'b0;
  bit ack0;
  int mh, ml, stray;

  always @(negedge clk) begin
    per_t e;
    if (meas && (bus.RISE === 1'b1 || bus.ACTIVE !== 1'b1)) begin
      meas = 1'b0;
      if (exp_q.size() == 0) begin
        chk("unexpected_period", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("high_len", mh, e.h);
        chk("low_len", ml, e.l);
        chk("start_ack", ack0, e.ack);
        chk("stray_ack", stray, 0);
      end
    end
    if (bus.RISE === 1'b1) begin
      chk("rise_o_high", bus.O, 1);
      chk("rise_prev_o_low", prev_o, 0);
      meas  = 1'b1;
      mh    = 0;
      ml    = 0;
      stray = 0;
      ack0  = bus.LOAD_ACK;
    end else if (meas && bus.LOAD_ACK === 1'b1) begin
      stray++;
    end
    if (meas) begin
      if (bus.O === 1'b1) mh++;
      else                ml++;
    end
    prev_o = bus.O;
  end

  // Reference model state: active ratio and a ratio waiting for a boundary.
  int cur;
  bit pf;
  int pv;
  bit nack;
  int off1[8], val1[8], off2[8], val2[8];
  int stop_off;

  function automatic int clampv(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 8; i++) begin
      off1[i] = -1; off2[i] = -1; val1[i] = 0; val2[i] = 0;
    end
  endtask

  task automatic idle_load(input int raw);
    bus.DIV  = DIV_W'(raw);
    bus.LOAD = 1'b1;
    tick();
    bus.LOAD = 1'b0;
    chk("idle_ack", bus.LOAD_ACK, 1);
    chk("idle_pend", bus.PEND, 0);
    cur = clampv(raw);
    tick();
    chk("idle_ack_clear", bus.LOAD_ACK, 0);
  endtask

  // Run nper periods; offsets count cycles within a period (last = wrap edge).
  task automatic run(input int nper, input bit rnd);
    int len;
    bit last;
    bit ld;
    int lv;
    bus.EN = 1'b1;
    tick();
    nack = 1'b0;
    for (int p = 0; p < nper; p++) begin
      len  = cur;
      last = (p == nper - 1);
      if (rnd) begin
        off1[p] = -1; off2[p] = -1;
        val1[p] = $urandom_range(0, 12);
        val2[p] = $urandom_range(0, 12);
        case ($urandom_range(0, 3))
          1: off1[p] = $urandom_range(0, len - 2);
          2: if (len >= 3) begin
               off1[p] = $urandom_range(0, len - 3);
               off2[p] = off1[p] + 1;
             end
          3: if (!last) off1[p] = len - 1;
          default: ;
        endcase
        if (last) stop_off = $urandom_range(0, len - 1);
      end
      exp_q.push_back('{h: len - len / 2, l: len / 2, ack: nack});
      nack = 1'b0;
      for (int o = 0; o < len; o++) begin
        ld = (o == off1[p]) || (o == off2[p]);
        lv = (o == off2[p]) ? val2[p] : val1[p];
        bus.EN   = !(last && o >= stop_off);
        bus.LOAD = ld;
        bus.DIV  = DIV_W'(lv);
        tick();
        bus.LOAD = 1'b0;
        if (o == len - 1 && pf) begin
          cur  = pv;
          pf   = 1'b0;
          nack = 1'b1;
        end
        if (ld) begin
          pf = 1'b1;
          pv = clampv(lv);
          chk("pend_set", bus.PEND, 1);
        end else if (o == len - 1) begin
          chk("pend_clear", bus.PEND, 0);
        end
        if (last && o == len - 1) begin
          chk("stop_active", bus.ACTIVE, 0);
          chk("stop_o", bus.O, 0);
          chk("stop_ack", bus.LOAD_ACK, nack);
        end
      end
    end
    bus.EN = 1'b0;
    tick();
    chk("idle_o", bus.O, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bus.EN   = 1'b0;
    bus.LOAD = 1'b0;
    bus.DIV  = '0;
    rst      = 1'b1;
    cur      = 2;
    pf       = 1'b0;
    pv       = 2;
    stop_off = 0;
    clear_plan();
    repeat (3) tick();
    rst = 1'b0;

    // Idle after reset: all outputs quiet.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_o", bus.O, 0);
      chk("rst_active", bus.ACTIVE, 0);
      chk("rst_pend", bus.PEND, 0);
      chk("rst_ack", bus.LOAD_ACK, 0);
    end

    // N=4 loaded in idle, six periods.
    clear_plan(); idle_load(4); stop_off = 0; run(6, 1'b0);

    // N=5 with a mid-period load of 3 at cnt=1.
    clear_plan(); idle_load(5); off1[0] = 1; val1[0] = 3; stop_off = 0; run(3, 1'b0);

    // N=6, EN dropped at cnt=1: full period still completes.
    clear_plan(); idle_load(6); stop_off = 1; run(1, 1'b0);

    // Two loads (1 then 0) in one period: both clamp to 2, single ack.
    clear_plan(); idle_load(4); off1[0] = 0; val1[0] = 1; off2[0] = 1; val2[0] = 0;
    stop_off = 0; run(3, 1'b0);

    // Load on the wrap edge applies one boundary later.
    clear_plan(); idle_load(3); off1[0] = 2; val1[0] = 7; stop_off = 0; run(3, 1'b0);

    // Reset while O is high at N=8: period truncated after two high cycles.
    clear_plan(); idle_load(8);
    bus.EN = 1'b1;
    exp_q.push_back('{h: 2, l: 0, ack: 1'b0});
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    bus.EN = 1'b0;
    chk("mid_rst_o", bus.O, 0);
    chk("mid_rst_active", bus.ACTIVE, 0);
`ifdef CLK_DIV_GEN_EDGE_COUNT_EN
    chk("mid_rst_edge_cnt", bus.EDGE_CNT, 0);
`endif
    cur = 2;
    pf  = 1'b0;
    stop_off = 0;
    run(1, 1'b0);

    // Randomized runs.
    for (int r = 0; r < 25; r++) begin
      clear_plan();
      if ($urandom_range(0, 1) == 1) idle_load($urandom_range(0, 12));
      run($urandom_range(1, 4), 1'b1);
    end

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
- Synchronous programmable clock divider that generates the source clock driven into a clock buffer input (the I side of CLK_BUF).
- Produces a registered divided clock O from the fabric clock C.
- Supports a glitch-free run/stop and a ratio-update handshake that takes effect only on period boundaries.
- No combinational path from C to O.

Parameters:
- DIV_W, 8, width of the divide-ratio input and internal counter.
- DEFAULT_DIV, 2, ratio loaded at reset; must be >= 2 and < 2**DIV_W.

Ports:
- C  input  1  fabric clock; all state updates on rising edge.
- R  input  1  synchronous reset, active-high.
- EN  input  1  run request; level-sensitive.
- DIV  input  DIV_W  requested divide ratio N; sampled only when LOAD=1.
- LOAD  input  1  one-cycle strobe; captures DIV into the pending register.
- LOAD_ACK  output  1  one-cycle pulse when a pending ratio becomes the active ratio.
- PEND  output  1  high while a captured ratio is waiting to be applied.
- ACTIVE  output  1  high while the state machine is in RUN.
- RISE  output  1  one-cycle pulse coincident with each O low-to-high transition.
- O  output  1  generated clock, registered.

Behaviour:
- Reset (R=1 at an edge):
  - state=IDLE, cnt=0, cur_div=DEFAULT_DIV, pend=0.
  - O=0, RISE=0, LOAD_ACK=0, PEND=0, ACTIVE=0.
  - Reset overrides every other input, including mid-period: O drops to 0 at that edge.
- Ratio clamp: a captured DIV value of 0 or 1 is stored as 2. All other values are used unchanged.
- Waveform in RUN for ratio N:
  - cnt counts 0..N-1 and then wraps to 0.
  - O = 1 while cnt < H, where H = N - floor(N/2); O = 0 otherwise.
  - Examples: N=4 gives 2 high / 2 low cycles; N=5 gives 3 high / 2 low.
- IDLE:
  - O=0, cnt held at 0.
  - If EN=1 at an edge: go to RUN, cnt<=0, O<=1, RISE<=1. O is visible high in the cycle after the first edge that samples EN=1.
- RUN, not at wrap (cnt != N-1): cnt<=cnt+1, and O is updated from the next cnt.
- RUN, at wrap (cnt == N-1), checked in this order:
  1. If pend=1: cur_div<=pend_div, pend<=0, LOAD_ACK<=1.
  2. If EN=0: go to IDLE, O<=0, cnt<=0, RISE<=0.
  3. Otherwise: cnt<=0, O<=1, RISE<=1; the new period uses the updated cur_div.
- Stopping is glitch-free: EN falling mid-period never truncates the current high or low phase. The full period always completes.
- LOAD handling:
  - LOAD=1 at an edge: pend_div<=clamp(DIV), pend<=1.
  - LOAD while pend=1 overwrites pend_div. Only one LOAD_ACK is issued, for the last value captured.
  - LOAD in IDLE applies at that same edge: cur_div updated, pend stays 0, LOAD_ACK=1 in the next cycle.
  - LOAD on the wrap edge itself is captured into pend_div and applied at the following wrap. The old pend_div, if any, is applied at this wrap.
- Output timing:
  - RISE and LOAD_ACK are registered one-cycle pulses.
  - ACTIVE = (state==RUN), registered.
  - PEND mirrors the pend register.

Optional Feature:
- Macro: CLK_DIV_GEN_EDGE_COUNT_EN.
- Defined:
  - Adds output port EDGE_CNT, 32 bits.
  - Increments by 1 (modulo 2**32) on every edge where RISE is set.
  - Cleared to 0 by R.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset with DEFAULT_DIV=2, hold EN=0 for 5 cycles -> O=0, ACTIVE=0, PEND=0, LOAD_ACK=0 throughout.
- LOAD with DIV=4 in IDLE, then EN=1 for 24 cycles:
  - LOAD_ACK pulses once in the cycle after the LOAD edge.
  - O shows exactly 6 periods of 2 high / 2 low; RISE pulses 6 times, aligned with O rising.
- Run at N=5, then pulse LOAD with DIV=3 when cnt=1:
  - PEND=1 until the wrap; LOAD_ACK pulses at the wrap.
  - Current period stays 3 high / 2 low; following periods are 2 high / 1 low.
- Run at N=6 and drop EN when cnt=1 -> O stays high through cnt=2 and low through cnt=5, then IDLE with O=0 and ACTIVE=0; no high pulse shorter than 3 cycles.
- LOAD with DIV=1, then LOAD with DIV=0 -> both clamp to 2; O toggles every cycle; a single LOAD_ACK is issued.
- Assert R for 1 cycle while O is high at N=8 -> O=0 and ACTIVE=0 in the next cycle, cur_div=2. With CLK_DIV_GEN_EDGE_COUNT_EN defined, EDGE_CNT=0.
